// File: rtl/npu_pkg.sv
// ============================================================================
//  Module  : npu_pkg
//  Purpose : Shared types, default sizing macros and the per-lane deskew depth helper.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ARRAY_SIZE
`define ARRAY_SIZE 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef BUFFER_WIDTH
`define BUFFER_WIDTH (`ARRAY_SIZE*`DATA_WIDTH)
`endif

package npu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } wb_state_t;

  // Lane i leaves the array i cycles late, so it needs N-1-i stages to line up.
  function automatic int LANE_DELAY(input int n, input int i);
    return n - 1 - i;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_delay_line.sv
// ============================================================================
//  Module  : lane_delay_line
//  Purpose : Enable-gated shift register of DEPTH stages; DEPTH=0 is a plain wire.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lane_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst_n, en};
      assign o_data   = i_data;
    end else begin : g_shift
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < DEPTH; s++) r_stage[s] <= '0;
        end else if (en) begin
          r_stage[0] <= i_data;
          for (int s = 1; s < DEPTH; s++) r_stage[s] <= r_stage[s-1];
        end
      end

      assign o_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/result_deskew_writer.sv
// ============================================================================
//  Module  : result_deskew_writer
//  Purpose : Realigns the skewed array result stream and writes it to the UB.
//            Optional RESULT_WB_RELU_EN clamps negative lanes to zero.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module result_deskew_writer
  import npu_pkg::*;
#(
  parameter int N            = `ARRAY_SIZE,
  parameter int DATA_WIDTH   = `DATA_WIDTH,
  parameter int ADDR_WIDTH   = `ADDR_WIDTH,
  parameter int BUFFER_WIDTH = `BUFFER_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [N*DATA_WIDTH-1:0] data_in_flat,
  input  logic                    first_in,
  input  logic                    last_in,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [BUFFER_WIDTH-1:0] wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  logic [N*DATA_WIDTH-1:0] w_deskew;
  logic [BUFFER_WIDTH-1:0] w_wdata;
  logic [1:0]              w_flags;
  logic                    w_first;
  logic                    w_last;

  wb_state_t               r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      lane_delay_line #(
        .DEPTH (LANE_DELAY(N, gi)),
        .WIDTH (DATA_WIDTH)
      ) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .i_data (data_in_flat[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH]),
        .o_data (w_deskew[(gi+1)*DATA_WIDTH-1 -: DATA_WIDTH])
      );
    end
  endgenerate

  // Flags ride with lane 0, so they take the same N-1 stages.
  lane_delay_line #(
    .DEPTH (N-1),
    .WIDTH (2)
  ) u_flags (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .i_data ({last_in, first_in}),
    .o_data (w_flags)
  );

  assign w_first = w_flags[0];
  assign w_last  = w_flags[1];

  always_comb begin
    w_wdata = w_deskew;
`ifdef RESULT_WB_RELU_EN
    for (int i = 0; i < N; i++) begin
      if (w_deskew[(i+1)*DATA_WIDTH-1]) w_wdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (en) begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_addr  <= base_addr;
              error   <= 1'b0;
              busy    <= 1'b1;
              r_state <= ARMED;
            end
          end
          ARMED: begin
            if (w_first) begin
              wr_en   <= 1'b1;
              wr_addr <= r_addr;
              wr_data <= w_wdata;
              r_addr  <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
              if (w_last) begin
                busy    <= 1'b0;
                r_state <= DONE;
              end else begin
                r_state <= STREAM;
              end
            end
          end
          STREAM: begin
            wr_en   <= 1'b1;
            wr_addr <= r_addr;
            wr_data <= w_wdata;
            r_addr  <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            if (w_first) error <= 1'b1;
            if (w_last) begin
              busy    <= 1'b0;
              r_state <= DONE;
            end
          end
          DONE: begin
            done    <= 1'b1;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
